// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS.hh BCD countdown with preset load, pause and expiry alarm.
// Define CDT_AUTO_RELOAD_EN to reload the preset on expiry and pulse alarm instead of stopping.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       load,
  input  logic [3:0] set_0,
  input  logic [3:0] set_1,
  input  logic [3:0] set_2,
  input  logic [3:0] set_3,
  input  logic [3:0] set_4,
  input  logic [3:0] set_5,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic [3:0] digit_5,
  output logic       running,
  output logic       alarm
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  state_t        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d, preset_q, preset_d, set_cl;
  logic [PW-1:0] pre_q, pre_d;
  logic          alarm_q, alarm_d, running_q, running_d, tick;
  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] m);
    return (v > m) ? m : v;
  endfunction
  function automatic logic [23:0] dec(input logic [23:0] c);
    logic [23:0] r;
    logic        b;
    r = c;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b) begin
        if (c[4*i +: 4] == 4'd0) r[4*i +: 4] = (i == 3) ? 4'd5 : (i == 5) ? 4'd0 : 4'd9;
        else begin
          r[4*i +: 4] = c[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction
  assign set_cl = {clamp(set_5, 4'd5), clamp(set_4, 4'd9), clamp(set_3, 4'd5),
                   clamp(set_2, 4'd9), clamp(set_1, 4'd9), clamp(set_0, 4'd9)};
  assign tick = (state_q == RUN) && (pre_q == PRE_LAST);
  assign {digit_5, digit_4, digit_3, digit_2, digit_1, digit_0} = cnt_q;
  assign running = running_q;
  assign alarm = alarm_q;
  // next-state: load overrides everything; RUN advances prescaler and counts down on tick
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    preset_d = preset_q;
    pre_d    = pre_q;
`ifdef CDT_AUTO_RELOAD_EN
    alarm_d  = 1'b0;
`else
    alarm_d  = alarm_q;
`endif
    if (load) begin
      state_d  = IDLE;
      cnt_d    = set_cl;
      preset_d = set_cl;
      pre_d    = '0;
      alarm_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_stop && cnt_q != 24'd0) begin
          state_d = RUN;
          pre_d   = '0;
        end
        RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (!start_stop) state_d = PAUSE;
          if (tick) begin
            if (cnt_q == 24'h000001) begin
              alarm_d = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
              cnt_d   = preset_q;
`else
              cnt_d   = 24'd0;
              state_d = EXPIRED;
`endif
            end else cnt_d = dec(cnt_q);
          end
        end
        PAUSE: if (start_stop) state_d = RUN;
        default: ;
      endcase
    end
    running_d = (state_d == RUN);
  end
  // state, count, preset, prescaler and registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      preset_q  <= '0;
      pre_q     <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      preset_q  <= preset_d;
      pre_q     <= pre_d;
      alarm_q   <= alarm_d;
      running_q <= running_d;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of load, countdown, borrow chain, clamping, pause and expiry.
module tb_countdown_timer;
  logic       clk = 1'b0, rst_n = 1'b0, start_stop = 1'b0, load = 1'b0;
  logic [3:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0, s4 = '0, s5 = '0;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic       running, alarm;
  logic [23:0] cnt;
  int errors = 0, checks = 0;
  countdown_timer #(.TICK_DIV(4)) dut (
    .clock(clk), .reset(rst_n), .start_stop(start_stop), .load(load),
    .set_0(s0), .set_1(s1), .set_2(s2), .set_3(s3), .set_4(s4), .set_5(s5),
    .digit_0(d0), .digit_1(d1), .digit_2(d2), .digit_3(d3), .digit_4(d4), .digit_5(d5),
    .running(running), .alarm(alarm)
  );
  assign cnt = {d5, d4, d3, d2, d1, d0};
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input logic [23:0] v);
    {s5, s4, s3, s2, s1, s0} = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_cnt", cnt, 24'h0);
    chk("rst_run", {23'd0, running}, 24'd0);
    chk("rst_alarm", {23'd0, alarm}, 24'd0);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_cnt", cnt, 24'h0);
    do_load(24'h000003);
    chk("load3", cnt, 24'h000003);
    chk("load3_run", {23'd0, running}, 24'd0);
    start_stop = 1'b1;
    cyc(1);
    chk("enter_run", {23'd0, running}, 24'd1);
    cyc(3);
    chk("cyc3", cnt, 24'h000003);
    cyc(1);
    chk("cyc4", cnt, 24'h000002);
    cyc(4);
    chk("cyc8", cnt, 24'h000001);
    cyc(4);
`ifdef CDT_AUTO_RELOAD_EN
    chk("reload_cnt", cnt, 24'h000003);
    chk("reload_alarm", {23'd0, alarm}, 24'd1);
    chk("reload_run", {23'd0, running}, 24'd1);
    cyc(1);
    chk("alarm_pulse_end", {23'd0, alarm}, 24'd0);
`else
    chk("exp_cnt", cnt, 24'h000000);
    chk("exp_alarm", {23'd0, alarm}, 24'd1);
    chk("exp_run", {23'd0, running}, 24'd0);
    start_stop = 1'b0;
    cyc(3);
    start_stop = 1'b1;
    cyc(5);
    chk("exp_hold_cnt", cnt, 24'h000000);
    chk("exp_hold_alarm", {23'd0, alarm}, 24'd1);
    chk("exp_hold_run", {23'd0, running}, 24'd0);
`endif
    do_load(24'h010000);
    chk("load_1min", cnt, 24'h010000);
    chk("load_clr_alarm", {23'd0, alarm}, 24'd0);
    chk("load_idle", {23'd0, running}, 24'd0);
    cyc(1);
    chk("run_1min", {23'd0, running}, 24'd1);
    cyc(4);
    chk("borrow_chain", cnt, 24'h005999);
    start_stop = 1'b0;
    do_load(24'h90700f);
    chk("clamp", cnt, 24'h505009);
    start_stop = 1'b1;
    cyc(2);
    start_stop = 1'b0;
    cyc(1);
    chk("pause_run", {23'd0, running}, 24'd0);
    cyc(9);
    chk("pause_cnt", cnt, 24'h505009);
    chk("pause_run2", {23'd0, running}, 24'd0);
    start_stop = 1'b1;
    cyc(1);
    chk("resume_run", {23'd0, running}, 24'd1);
    cyc(1);
    chk("resume_no_tick", cnt, 24'h505009);
    cyc(1);
    chk("resume_tick", cnt, 24'h505008);
    cyc(3);
    chk("pre_tick_cnt", cnt, 24'h505008);
    do_load(24'h000407);
    chk("load_vs_tick", cnt, 24'h000407);
    chk("load_vs_tick_run", {23'd0, running}, 24'd0);
    start_stop = 1'b0;
    do_load(24'h000000);
    start_stop = 1'b1;
    cyc(3);
    chk("zero_run", {23'd0, running}, 24'd0);
    chk("zero_alarm", {23'd0, alarm}, 24'd0);
    chk("zero_cnt", cnt, 24'h000000);
    start_stop = 1'b0;
    do_load(24'h000105);
    start_stop = 1'b1;
    cyc(3);
    chk("mid_run", {23'd0, running}, 24'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt", cnt, 24'h000000);
    chk("async_run", {23'd0, running}, 24'd0);
    chk("async_alarm", {23'd0, alarm}, 24'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk("preset_lost_run", {23'd0, running}, 24'd0);
    chk("preset_lost_cnt", cnt, 24'h000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
